// File: rtl/riscv_pkg.sv
// Shared decode-side definitions: result-source encodings, ALU control width/NOP,
// and the ID/EX control-bundle layout with its bubble value.
package riscv_pkg;

    typedef enum logic [1:0] {
        RESULTSRC_ALU = 2'b00,
        RESULTSRC_MEM = 2'b01,
        RESULTSRC_PC4 = 2'b10
    } resultsrc_t;

    localparam int unsigned ALUCTRL_W = 3;
    localparam logic [ALUCTRL_W-1:0] ALUCTRL_NOP = '0;

    typedef struct packed {
        logic                 regwr;
        logic                 memwr;
        logic                 branch;
        logic                 jump;
        logic                 jalr;
        logic                 alusrc;
        resultsrc_t           resultsrc;
        logic [ALUCTRL_W-1:0] aluctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        regwr:     1'b0,
        memwr:     1'b0,
        branch:    1'b0,
        jump:      1'b0,
        jalr:      1'b0,
        alusrc:    1'b0,
        resultsrc: RESULTSRC_ALU,
        aluctrl:   ALUCTRL_NOP
    };

endpackage

// File: rtl/id_ex_perf_cnt.sv
// ID/EX event counters (bubbles, stalls, illegal decodes); only instantiated
// when ID_EX_PERF_CNT_EN is defined. Counters wrap naturally.
module id_ex_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubble_ev,
    input  logic             stall_ev,
    input  logic             illegal_ev,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt  <= '0;
            stall_cnt   <= '0;
            illegal_cnt <= '0;
        end else begin
            if (bubble_ev)  bubble_cnt  <= bubble_cnt + 1'b1;
            if (stall_ev)   stall_cnt   <= stall_cnt + 1'b1;
            if (illegal_ev) illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush and illegal/invalid scrub to a NOP bubble.
// Define ID_EX_PERF_CNT_EN to add bubble_cnt / stall_cnt / illegal_cnt outputs.
module id_ex_pipe_reg
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REGA_W = 5
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic              illegal_d,
    input  logic              regwr_d,
    input  logic              memwr_d,
    input  logic              branch_d,
    input  logic              jump_d,
    input  logic              jalr_d,
    input  logic              alusrc_d,
    input  logic [1:0]        resultsrc_d,
    input  logic [2:0]        aluctrl_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pcplus4_d,
    input  logic [XLEN-1:0]   immext_d,
    input  logic [REGA_W-1:0] rs1_d,
    input  logic [REGA_W-1:0] rs2_d,
    input  logic [REGA_W-1:0] rd_d,
    output logic              valid_e,
    output logic              regwr_e,
    output logic              memwr_e,
    output logic              branch_e,
    output logic              jump_e,
    output logic              jalr_e,
    output logic              alusrc_e,
    output logic [1:0]        resultsrc_e,
    output logic [2:0]        aluctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pcplus4_e,
    output logic [XLEN-1:0]   immext_e,
    output logic [REGA_W-1:0] rs1_e,
    output logic [REGA_W-1:0] rs2_e,
    output logic [REGA_W-1:0] rd_e
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
`endif
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  load_ok;
    logic  clear;
    logic  hold;

    // Flush always wins; otherwise an unusable decode slot becomes a bubble unless stalled.
    assign load_ok = valid_d & ~illegal_d;
    assign clear   = flush_e | (~stall_e & ~load_ok);
    assign hold    = stall_e & ~flush_e;

    always_comb begin
        ctrl_d           = CTRL_BUBBLE;
        ctrl_d.regwr     = regwr_d;
        ctrl_d.memwr     = memwr_d;
        ctrl_d.branch    = branch_d;
        ctrl_d.jump      = jump_d;
        ctrl_d.jalr      = jalr_d;
        ctrl_d.alusrc    = alusrc_d;
        ctrl_d.resultsrc = resultsrc_t'(resultsrc_d);
        ctrl_d.aluctrl   = aluctrl_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_e <= 1'b0;
        end else if (clear) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_e <= 1'b0;
        end else if (!hold) begin
            ctrl_q  <= ctrl_d;
            valid_e <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_e     <= '0;
            rd2_e     <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
            immext_e  <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (clear) begin
            rd1_e     <= '0;
            rd2_e     <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
            immext_e  <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (!hold) begin
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            pc_e      <= pc_d;
            pcplus4_e <= pcplus4_d;
            immext_e  <= immext_d;
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            rd_e      <= rd_d;
        end
    end

    assign regwr_e     = ctrl_q.regwr;
    assign memwr_e     = ctrl_q.memwr;
    assign branch_e    = ctrl_q.branch;
    assign jump_e      = ctrl_q.jump;
    assign jalr_e      = ctrl_q.jalr;
    assign alusrc_e    = ctrl_q.alusrc;
    assign resultsrc_e = ctrl_q.resultsrc;
    assign aluctrl_e   = ctrl_q.aluctrl;

`ifdef ID_EX_PERF_CNT_EN
    id_ex_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .bubble_ev   (clear),
        .stall_ev    (hold),
        .illegal_ev  (valid_d & illegal_d & ~stall_e & ~flush_e),
        .bubble_cnt  (bubble_cnt),
        .stall_cnt   (stall_cnt),
        .illegal_cnt (illegal_cnt)
    );
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; counter checks compile in
// only when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic        stall_e, flush_e, valid_d, illegal_d;
    logic        regwr_d, memwr_d, branch_d, jump_d, jalr_d, alusrc_d;
    logic [1:0]  resultsrc_d;
    logic [2:0]  aluctrl_d;
    logic [31:0] rd1_d, rd2_d, pc_d, pcplus4_d, immext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        valid_e, regwr_e, memwr_e, branch_e, jump_e, jalr_e, alusrc_e;
    logic [1:0]  resultsrc_e;
    logic [2:0]  aluctrl_e;
    logic [31:0] rd1_e, rd2_e, pc_e, pcplus4_e, immext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt, illegal_cnt;
`endif

    logic [11:0]  ctrl_bus;
    logic [174:0] data_bus;
    assign ctrl_bus = {valid_e, regwr_e, memwr_e, branch_e, jump_e, jalr_e, alusrc_e,
                       resultsrc_e, aluctrl_e};
    assign data_bus = {rd1_e, rd2_e, pc_e, pcplus4_e, immext_e, rs1_e, rs2_e, rd_e};

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    id_ex_pipe_reg #(
        .XLEN   (32),
        .REGA_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_e     (stall_e),
        .flush_e     (flush_e),
        .valid_d     (valid_d),
        .illegal_d   (illegal_d),
        .regwr_d     (regwr_d),
        .memwr_d     (memwr_d),
        .branch_d    (branch_d),
        .jump_d      (jump_d),
        .jalr_d      (jalr_d),
        .alusrc_d    (alusrc_d),
        .resultsrc_d (resultsrc_d),
        .aluctrl_d   (aluctrl_d),
        .rd1_d       (rd1_d),
        .rd2_d       (rd2_d),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .immext_d    (immext_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_d        (rd_d),
        .valid_e     (valid_e),
        .regwr_e     (regwr_e),
        .memwr_e     (memwr_e),
        .branch_e    (branch_e),
        .jump_e      (jump_e),
        .jalr_e      (jalr_e),
        .alusrc_e    (alusrc_e),
        .resultsrc_e (resultsrc_e),
        .aluctrl_e   (aluctrl_e),
        .rd1_e       (rd1_e),
        .rd2_e       (rd2_e),
        .pc_e        (pc_e),
        .pcplus4_e   (pcplus4_e),
        .immext_e    (immext_e),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt  (bubble_cnt),
        .stall_cnt   (stall_cnt),
        .illegal_cnt (illegal_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain valid instruction with all controls/data zeroed; callers overwrite fields.
    task automatic nop_d();
        stall_e = 0; flush_e = 0; valid_d = 1; illegal_d = 0;
        regwr_d = 0; memwr_d = 0; branch_d = 0; jump_d = 0; jalr_d = 0; alusrc_d = 0;
        resultsrc_d = 2'b00; aluctrl_d = 3'b000;
        rd1_d = 0; rd2_d = 0; pc_d = 0; pcplus4_d = 0; immext_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0;
    endtask

    initial begin
        rst_n = 0;
        nop_d();
        regwr_d = 1; memwr_d = 1; jump_d = 1; resultsrc_d = 2'b01; aluctrl_d = 3'b101;
        rd1_d = $urandom; rd2_d = $urandom; pc_d = $urandom; pcplus4_d = $urandom;
        immext_d = $urandom; rs1_d = 5'd7; rs2_d = 5'd9; rd_d = 5'd11;
        #2;
        check("reset_ctrl_async", ctrl_bus, 0);
        check("reset_data_async", data_bus, 0);
        step(); step();
        check("reset_ctrl_held", ctrl_bus, 0);
        check("reset_data_held", data_bus, 0);

        // lw x5, 8(x2)
        rst_n = 1;
        nop_d();
        regwr_d = 1; alusrc_d = 1; resultsrc_d = 2'b01; rd_d = 5'd5; rs1_d = 5'd2;
        rd1_d = 32'h1000; immext_d = 32'd8; pc_d = 32'h100; pcplus4_d = 32'h104;
        step();
        check("lw_ctrl", ctrl_bus, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000});
        check("lw_rd", rd_e, 5);
        check("lw_rd1", rd1_e, 32'h1000);
        check("lw_imm", immext_e, 8);
        check("lw_pc", {pc_e, pcplus4_e}, {32'h100, 32'h104});

        // add x3, x1, x4 then stall 3 cycles with changing inputs
        nop_d();
        regwr_d = 1; rd_d = 5'd3; rs1_d = 5'd1; rs2_d = 5'd4; rd1_d = 32'd11; rd2_d = 32'd22;
        aluctrl_d = 3'b000; pc_d = 32'h108;
        step();
        check("add_rd", rd_e, 3);
        check("add_rd1", rd1_e, 11);
        stall_e = 1;
        for (int i = 0; i < 3; i++) begin
            memwr_d = 1; regwr_d = 0; rd_d = 5'(9 + i); rd1_d = 32'(100 + i); pc_d = 32'(i);
            step();
            check("stall_ctrl", ctrl_bus, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000});
            check("stall_rd", rd_e, 3);
            check("stall_rd1", rd1_e, 11);
            check("stall_pc", pc_e, 32'h108);
        end
        stall_e = 0;
        step();
        check("unstall_rd", rd_e, 11);
        check("unstall_memwr", {memwr_e, regwr_e}, 2'b10);
        check("unstall_rd1", rd1_e, 102);

        // sw with stall+flush: flush wins
        nop_d();
        memwr_d = 1; alusrc_d = 1; rs1_d = 5'd2; rs2_d = 5'd6; rd_d = 5'd7; rd2_d = 32'hABCD;
        stall_e = 1; flush_e = 1;
        step();
        check("flush_ctrl", ctrl_bus, 0);
        check("flush_data", data_bus, 0);

        // illegal decode with X controls
        nop_d();
        illegal_d = 1;
        regwr_d = 1'bx; memwr_d = 1'bx; branch_d = 1'bx; jump_d = 1'bx; jalr_d = 1'bx;
        alusrc_d = 1'bx; aluctrl_d = 3'bxxx; rd_d = 5'd12; rd1_d = 32'h55;
        step();
        check("illegal_ctrl", ctrl_bus, 0);
        check("illegal_data", data_bus, 0);

        // jal x1 -> beq (SUB) -> invalid slot
        nop_d();
        jump_d = 1; regwr_d = 1; resultsrc_d = 2'b10; pc_d = 32'h100; pcplus4_d = 32'h104; rd_d = 5'd1;
        step();
        check("jal_ctrl", ctrl_bus, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000});
        check("jal_pc4", pcplus4_e, 32'h104);
        nop_d();
        branch_d = 1; aluctrl_d = 3'b001; rs1_d = 5'd8; rs2_d = 5'd9; pc_d = 32'h104;
        step();
        check("beq_ctrl", ctrl_bus, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b001});
        check("beq_rs", {rs1_e, rs2_e}, {5'd8, 5'd9});
        nop_d();
        valid_d = 0; regwr_d = 1; jalr_d = 1; rd_d = 5'd4;
        step();
        check("bubble_ctrl", ctrl_bus, 0);
        check("bubble_rd", rd_e, 0);

        // jalr with stall held, then reset asserted mid-cycle
        nop_d();
        jalr_d = 1; regwr_d = 1; resultsrc_d = 2'b10; rd_d = 5'd1; rs1_d = 5'd5;
        step();
        check("jalr_ctrl", ctrl_bus, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 3'b000});
        stall_e = 1;
        #2;
        rst_n = 0;
        #1;
        check("rst_midstall_ctrl", ctrl_bus, 0);
        check("rst_midstall_data", data_bus, 0);
        step();
        rst_n = 1;

`ifdef ID_EX_PERF_CNT_EN
        rst_n = 0;
        nop_d();
        #1;
        check("cnt_reset", {bubble_cnt, stall_cnt, illegal_cnt}, 0);
        rst_n = 1;
        step();
        flush_e = 1; step(); step();
        flush_e = 0; stall_e = 1; step(); step(); step();
        stall_e = 0; illegal_d = 1; step();
        illegal_d = 0; step();
        check("bubble_cnt", bubble_cnt, 3);
        check("stall_cnt", stall_cnt, 3);
        check("illegal_cnt", illegal_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
